// File: rtl/lcd_spi_serializer_if.sv
// lcd_spi_serializer_if
//
// FIFO read-port handshake between the LCD command/pixel FIFO and the
// SPI serializer.
//
// Signals:
//   fifo_read_valid  FIFO holds a word
//   fifo_read_data   {dc, byte}: bit 8 = D/C (0 command, 1 data), bits 7:0 payload
//   fifo_read_ready  serializer accepts a word this cycle
//
// Modports:
//   master  FIFO side (drives valid/data, observes ready)
//   slave   serializer side (observes valid/data, drives ready)

interface lcd_spi_serializer_if;
    logic       fifo_read_valid;
    logic [8:0] fifo_read_data;
    logic       fifo_read_ready;

    modport master (
        output fifo_read_valid,
        output fifo_read_data,
        input  fifo_read_ready
    );

    modport slave (
        input  fifo_read_valid,
        input  fifo_read_data,
        output fifo_read_ready
    );
endinterface

// File: rtl/lcd_spi_serializer.sv
// lcd_spi_serializer
//
// Consumer end of the LCD command/pixel FIFO. Pops 9-bit {dc, byte} words
// and shifts each payload MSB-first onto a write-only SPI mode-0 bus for an
// ST7789 panel. The panel reset pin is not driven here.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (1..255)
//   CS_GAP   minimum clk cycles with lcd_csn high after a released byte (1..255)
//
// Optional feature macro:
//   LCD_CS_BURST_EN  when defined, chip select is held low across back-to-back
//                    words; the END cycle may accept the next word directly.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   fifo      FIFO read handshake (slave modport)
//   lcd_csn   chip select, active low
//   lcd_sclk  SPI clock, idles low
//   lcd_mosi  serial data, MSB first, stable across every rising sclk
//   lcd_dc    0 command, 1 data; stable for the whole byte
//   busy      high from accept until return to IDLE

module lcd_spi_serializer #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_spi_serializer_if.slave  fifo,
    output logic                 lcd_csn,
    output logic                 lcd_sclk,
    output logic                 lcd_mosi,
    output logic                 lcd_dc,
    output logic                 busy
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_END  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t     state_r;
    logic [7:0] div_cnt_r;
    logic [2:0] bit_cnt_r;
    // Holds the bits still to be sent after the one currently on lcd_mosi.
    logic [6:0] shift_r;
    logic       ready_s;
    logic       accept_s;

    // Ready decode: state only, forced low while reset is asserted so no word
    // can be popped during reset.
    always_comb begin
        ready_s = 1'b0;
        if (!rst_n) begin
            ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: ready_s = 1'b1;
`ifdef LCD_CS_BURST_EN
                ST_END:  ready_s = 1'b1;
`endif
                default: ready_s = 1'b0;
            endcase
        end
    end

    assign fifo.fifo_read_ready = ready_s;
    assign accept_s             = fifo.fifo_read_valid && ready_s;

    // Serializer FSM with registered pin outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= 8'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 7'd0;
            lcd_csn   <= 1'b1;
            lcd_sclk  <= 1'b0;
            lcd_mosi  <= 1'b0;
            lcd_dc    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lcd_csn   <= 1'b0;
                        lcd_dc    <= fifo.fifo_read_data[8];
                        lcd_mosi  <= fifo.fifo_read_data[7];
                        shift_r   <= fifo.fifo_read_data[6:0];
                        bit_cnt_r <= 3'd7;
                        div_cnt_r <= 8'd0;
                        busy      <= 1'b1;
                        state_r   <= ST_LOW;
                    end else begin
                        lcd_csn  <= 1'b1;
                        lcd_sclk <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= 8'd0;
                        lcd_sclk  <= 1'b1;
                        state_r   <= ST_HIGH;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= 8'd0;
                        lcd_sclk  <= 1'b0;
                        if (bit_cnt_r == 3'd0) begin
                            state_r <= ST_END;
                        end else begin
                            // Next bit goes out on the falling edge so it is
                            // settled well before the following rise.
                            bit_cnt_r <= bit_cnt_r - 3'd1;
                            lcd_mosi  <= shift_r[6];
                            shift_r   <= {shift_r[5:0], 1'b0};
                            state_r   <= ST_LOW;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                ST_END: begin
`ifdef LCD_CS_BURST_EN
                    if (accept_s) begin
                        // Chain the next word without releasing chip select;
                        // sclk is already low so dc may change safely.
                        lcd_dc    <= fifo.fifo_read_data[8];
                        lcd_mosi  <= fifo.fifo_read_data[7];
                        shift_r   <= fifo.fifo_read_data[6:0];
                        bit_cnt_r <= 3'd7;
                        div_cnt_r <= 8'd0;
                        state_r   <= ST_LOW;
                    end else begin
                        lcd_csn   <= 1'b1;
                        div_cnt_r <= 8'd0;
                        state_r   <= ST_GAP;
                    end
`else
                    lcd_csn   <= 1'b1;
                    div_cnt_r <= 8'd0;
                    state_r   <= ST_GAP;
`endif
                end
                ST_GAP: begin
                    if (div_cnt_r == GAP_LAST) begin
                        div_cnt_r <= 8'd0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        div_cnt_r <= div_cnt_r + 8'd1;
                    end
                end
                default: begin
                    lcd_csn  <= 1'b1;
                    lcd_sclk <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_serializer.sv
// tb_lcd_spi_serializer
//
// Directed bench for lcd_spi_serializer. Instance u_dut uses CLK_DIV=2,
// CS_GAP=2 and is fed from a small FIFO model; instance u_dut1 uses
// CLK_DIV=1 and is driven directly. Expectations for the back-to-back
// stream follow LCD_CS_BURST_EN when it is defined for the build.

module tb_lcd_spi_serializer;

    logic clk;
    logic rst_n;

    lcd_spi_serializer_if bus0 ();
    lcd_spi_serializer_if bus1 ();

    logic csn0, sclk0, mosi0, dc0, busy0;
    logic csn1, sclk1, mosi1, dc1, busy1;

    lcd_spi_serializer #(.CLK_DIV(2), .CS_GAP(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fifo     (bus0),
        .lcd_csn  (csn0),
        .lcd_sclk (sclk0),
        .lcd_mosi (mosi0),
        .lcd_dc   (dc0),
        .busy     (busy0)
    );

    lcd_spi_serializer #(.CLK_DIV(1), .CS_GAP(2)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .fifo     (bus1),
        .lcd_csn  (csn1),
        .lcd_sclk (sclk1),
        .lcd_mosi (mosi1),
        .lcd_dc   (dc1),
        .busy     (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model feeding u_dut
    logic [8:0] wq[$];
    logic [8:0] popped[$];
    int         accept_cyc[$];
    bit         src_en = 1'b0;
    int         cyc = 0;

    initial begin
        logic take;
        bus0.fifo_read_valid = 1'b0;
        bus0.fifo_read_data  = 9'h0C3;
        forever begin
            @(negedge clk);
            take = bus0.fifo_read_valid && bus0.fifo_read_ready;
            @(posedge clk);
            #1;
            if (take) begin
                popped.push_back(wq.pop_front());
                accept_cyc.push_back(cyc);
            end
            if (src_en && wq.size() > 0) begin
                bus0.fifo_read_valid = 1'b1;
                bus0.fifo_read_data  = wq[0];
            end else begin
                bus0.fifo_read_valid = 1'b0;
                bus0.fifo_read_data  = 9'h0C3;
            end
        end
    end

    // Bus monitor on u_dut, sampled on the falling clk edge
    logic rise_bits[$];
    logic rise_dc[$];
    int   low_lens[$];
    int   high_lens[$];
    int   rdy_lows[$];
    int   n_viol = 0;

    initial begin
        logic sclk_p, mosi_p, dc_p, csn_p;
        int   low_run, high_run, rdy_low;
        sclk_p = 1'b0; mosi_p = 1'b0; dc_p = 1'b0; csn_p = 1'b1;
        low_run = 0; high_run = 0; rdy_low = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sclk0 === 1'b1 && sclk_p === 1'b0) begin
                rise_bits.push_back(mosi0);
                rise_dc.push_back(dc0);
                if (csn0 !== 1'b0) n_viol++;
            end
            if (sclk_p === 1'b1 && sclk0 === 1'b1 && mosi0 !== mosi_p) n_viol++;
            if (csn0 === 1'b0 && csn_p === 1'b0 && sclk0 === 1'b1 && dc0 !== dc_p) n_viol++;
            if (csn0 === 1'b0) begin
                low_run++;
                if (high_run > 0) high_lens.push_back(high_run);
                high_run = 0;
            end else begin
                high_run++;
                if (low_run > 0) low_lens.push_back(low_run);
                low_run = 0;
            end
            if (bus0.fifo_read_ready !== 1'b1) begin
                rdy_low++;
            end else begin
                if (rdy_low > 0) rdy_lows.push_back(rdy_low);
                rdy_low = 0;
            end
            sclk_p = sclk0; mosi_p = mosi0; dc_p = dc0; csn_p = csn0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rise_bits.delete();
        rise_dc.delete();
        low_lens.delete();
        high_lens.delete();
        rdy_lows.delete();
        accept_cyc.delete();
        popped.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy0 || wq.size() != 0 || bus0.fifo_read_valid) && n < 500) begin
            step(1);
            n++;
        end
        check_val({tag, "_done_in_time"}, 32'(n < 500), 32'd1);
        step(3);
    endtask

    function automatic logic [7:0] byte_at(input int k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (k + i < rise_bits.size()) b = {b[6:0], rise_bits[k + i]};
        end
        return b;
    endfunction

    function automatic logic dc_at(input int k);
        if (k < rise_dc.size()) return rise_dc[k];
        return 1'bx;
    endfunction

    initial begin
        int   n;
        int   r1, first1, last1, lowc1, dcbad1;
        logic p1;
        logic [7:0] b1;

        rst_n = 1'b0;
        bus1.fifo_read_valid = 1'b0;
        bus1.fifo_read_data  = 9'h000;

        // Reset with valid high and 0x1AA offered: nothing popped
        wq.push_back(9'h1AA);
        src_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_val("reset_outputs", {26'd0, csn0, sclk0, mosi0, dc0, busy0, bus0.fifo_read_ready},
                      32'b100000);
        end
        check_val("reset_no_pop", popped.size(), 32'd0);
        rst_n = 1'b1;
        #1;
        check_val("ready_after_release", bus0.fifo_read_ready, 32'd1);
        wait_idle("rst_word");
        check_val("rst_word_pops", popped.size(), 32'd1);
        if (popped.size() > 0) check_val("rst_word_value", popped[0], 32'h1AA);
        check_val("rst_word_bits", byte_at(0), 32'hAA);
        check_val("rst_word_dc", dc_at(0), 32'd1);

        // Single command 0x011, CLK_DIV=2
        clear_logs();
        wq.push_back(9'h011);
        wait_idle("cmd11");
        check_val("cmd11_rises", rise_bits.size(), 32'd8);
        check_val("cmd11_bits", byte_at(0), 32'h11);
        check_val("cmd11_dc_first", dc_at(0), 32'd0);
        check_val("cmd11_dc_last", dc_at(7), 32'd0);
        check_val("cmd11_csn_windows", low_lens.size(), 32'd1);
        if (low_lens.size() > 0) check_val("cmd11_csn_low_len", low_lens[0], 32'd33);
        check_val("cmd11_ready_windows", rdy_lows.size(), 32'd1);
        if (rdy_lows.size() > 0) check_val("cmd11_ready_low_len", rdy_lows[0], 32'd35);

        // Single data word 0x1A5 on the CLK_DIV=1 instance
        bus1.fifo_read_valid = 1'b1;
        bus1.fifo_read_data  = 9'h1A5;
        step(1);
        bus1.fifo_read_valid = 1'b0;
        bus1.fifo_read_data  = 9'h05A;
        check_val("d1_busy_after_accept", busy1, 32'd1);
        r1 = 0; first1 = -1; last1 = -1; lowc1 = 0; dcbad1 = 0; p1 = 1'b0; b1 = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (csn1 === 1'b0) lowc1++;
            if (sclk1 === 1'b1 && p1 === 1'b0) begin
                b1 = {b1[6:0], mosi1};
                if (first1 < 0) first1 = i;
                last1 = i;
                r1++;
                if (dc1 !== 1'b1) dcbad1++;
            end
            p1 = sclk1;
        end
        check_val("d1_rises", r1, 32'd8);
        check_val("d1_bits", b1, 32'hA5);
        check_val("d1_rise_span", last1 - first1, 32'd14);
        check_val("d1_csn_low_len", lowc1, 32'd17);
        check_val("d1_dc_bad", dcbad1, 32'd0);
        step(1);

        // Back-to-back stream 0x02A, 0x100, 0x128
        clear_logs();
        wq.push_back(9'h02A);
        wq.push_back(9'h100);
        wq.push_back(9'h128);
        wait_idle("stream");
        check_val("stream_rises", rise_bits.size(), 32'd24);
        check_val("stream_byte0", byte_at(0), 32'h2A);
        check_val("stream_byte1", byte_at(8), 32'h00);
        check_val("stream_byte2", byte_at(16), 32'h28);
        check_val("stream_dc_seq", {29'd0, dc_at(0), dc_at(8), dc_at(16)}, 32'b011);
        check_val("stream_pops", popped.size(), 32'd3);
        check_val("stream_accepts", accept_cyc.size(), 32'd3);
`ifdef LCD_CS_BURST_EN
        check_val("burst_csn_windows", low_lens.size(), 32'd1);
        if (low_lens.size() > 0) check_val("burst_csn_low_len", low_lens[0], 32'd99);
        if (accept_cyc.size() == 3) begin
            check_val("burst_spacing1", accept_cyc[1] - accept_cyc[0], 32'd33);
            check_val("burst_spacing2", accept_cyc[2] - accept_cyc[1], 32'd33);
        end
`else
        check_val("nb_csn_windows", low_lens.size(), 32'd3);
        for (int i = 0; i < low_lens.size(); i++) check_val("nb_csn_low_len", low_lens[i], 32'd33);
        check_val("nb_gap_count", high_lens.size(), 32'd3);
        for (int i = 1; i < high_lens.size(); i++) check_val("nb_csn_gap_len", high_lens[i], 32'd3);
        if (accept_cyc.size() == 3) begin
            check_val("nb_spacing1", accept_cyc[1] - accept_cyc[0], 32'd36);
            check_val("nb_spacing2", accept_cyc[2] - accept_cyc[1], 32'd36);
        end
`endif

        // Reset at the 4th sclk rise of 0x1F0, then 0x1F8 offered
        clear_logs();
        wq.push_back(9'h1F0);
        n = 0;
        while (rise_bits.size() < 4 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("midrst_reached_rise4", rise_bits.size(), 32'd4);
        rst_n = 1'b0;
        wq.push_back(9'h1F8);
        step(1);
        check_val("midrst_outputs", {26'd0, csn0, sclk0, mosi0, dc0, busy0, bus0.fifo_read_ready},
                  32'b100000);
        step(2);
        check_val("midrst_no_extra_rise", rise_bits.size(), 32'd4);
        check_val("midrst_pops_in_reset", popped.size(), 32'd1);
        rst_n = 1'b1;
        wait_idle("midrst");
        check_val("midrst_total_rises", rise_bits.size(), 32'd12);
        check_val("midrst_partial_bits", {28'd0, rise_bits[0], rise_bits[1], rise_bits[2], rise_bits[3]},
                  32'hF);
        check_val("midrst_new_byte", byte_at(4), 32'hF8);
        check_val("midrst_new_dc", dc_at(4), 32'd1);
        check_val("midrst_pops", popped.size(), 32'd2);
        if (popped.size() == 2) begin
            check_val("midrst_pop0", popped[0], 32'h1F0);
            check_val("midrst_pop1", popped[1], 32'h1F8);
        end

        check_val("bus_rule_violations", n_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_spi_serializer.md
# lcd_spi_serializer

Consumer end of the LCD command/pixel FIFO. Pops 9-bit words (bit 8 = D/C: 0 command, 1 data; bits 7:0 payload) over a valid/ready handshake and shifts each payload MSB-first onto the 4-wire SPI bus of the 240x135 ST7789 panel (mode 0, write-only). Sits between the FIFO read port and the LCD pins; the panel reset pin is not driven here.

## Interface

- CLK_DIV, 2: SCLK half-period in clk cycles; legal range 1..255.
- CS_GAP, 2: minimum clk cycles with lcd_csn high between bytes when CS is released; legal range 1..255.

- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- fifo_read_valid  in  1  FIFO holds a word
- fifo_read_data  in  9  {dc, byte}
- fifo_read_ready  out  1  serializer accepts a word this cycle
- lcd_csn  out  1  chip select, active low
- lcd_sclk  out  1  SPI clock, idles low
- lcd_mosi  out  1  serial data, MSB first
- lcd_dc  out  1  0 command, 1 data; stable for the whole byte
- busy  out  1  high from accept until return to IDLE

## Operation

- Transfer occurs on a rising clk edge with fifo_read_valid && fifo_read_ready. Data is latched into an 8-bit shift register and bit 8 into lcd_dc at that edge.
- fifo_read_ready is combinational from state only: high in IDLE, and in END when LCD_CS_BURST_EN is defined. It never depends on fifo_read_valid.
- States:
  - IDLE: csn=1, sclk=0, busy=0. On transfer: csn<=0, dc<=d[8], mosi<=d[7], bit_cnt<=7, div_cnt<=0, go LOW.
  - LOW: sclk=0. After CLK_DIV cycles, sclk<=1 and go HIGH.
  - HIGH: sclk=1. After CLK_DIV cycles, sclk<=0. If bit_cnt==0, go END. Otherwise decrement bit_cnt, mosi<=next bit, and go LOW.
  - END: one cycle; behaviour depends on configuration.
  - GAP: csn=1. Hold for CS_GAP cycles, then go IDLE.
- mosi changes only on sclk falling edges or on load, so it is stable across every rising edge.
- div_cnt is 8 bits, bit_cnt is 3 bits. Neither counter wraps beyond its terminal value.
- fifo_read_data is ignored when no transfer occurs. A word is popped exactly once; there is no retransmit.
- Reset mid-byte: at the next clk edge with rst_n low, all outputs take their reset values. The partial byte is abandoned and never re-fetched.
- rst_n low with fifo_read_valid high: no pop occurs (ready=0 during reset).

## Timing

- Reset values: lcd_csn=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, fifo_read_ready=0, busy=0. State is IDLE. ready rises on the first cycle after release.
- Accept edge at cycle 0 gives csn low from cycle 1.
- First sclk rise occurs at cycle 1+CLK_DIV. Each bit lasts 2*CLK_DIV cycles.
- The 8th sclk fall occurs at cycle 1+16*CLK_DIV, which is the END cycle.
- Non-burst byte period, accept to next possible accept: 16*CLK_DIV + 2 + CS_GAP cycles.
- Burst byte period: 16*CLK_DIV + 1 cycles.
- lcd_dc is valid at csn fall, at least CLK_DIV cycles before the first rising sclk edge.

## Configuration

- LCD_CS_BURST_EN defined:
  - END asserts fifo_read_ready.
  - If valid in END: load the next word as in IDLE, keep csn=0, go LOW. lcd_dc may change here while sclk is low.
  - If not valid in END: csn<=1, go GAP.
- LCD_CS_BURST_EN undefined:
  - END never accepts. It always sets csn<=1 and goes GAP, so every byte is framed by its own CS pulse.

## Test plan

- Reset: hold rst_n low 5 cycles with valid=1 and data 0x1AA → csn=1, sclk=0, ready=0, no pop. After release, ready=1 within 1 cycle.
- Single command, CLK_DIV=2, word 0x011 → dc=0, mosi samples on sclk rises = 0,0,0,1,0,0,0,1. 8 rising edges; csn low for exactly 33 cycles; ready low for 35 cycles.
- Single data word, CLK_DIV=1, word 0x1A5 → dc=1, bits 1,0,1,0,0,1,0,1, sclk period 2 cycles.
- Back-to-back 0x02A, 0x100, 0x128 always valid, burst undefined, CS_GAP=2 → three csn pulses. csn high for at least 3 cycles between bytes. dc sequence 0,1,1.
- Same stream with LCD_CS_BURST_EN → a single csn low window. Accepts spaced 16*CLK_DIV+1 cycles apart. dc switches 0→1 only while sclk=0.
- Reset asserted at the 4th sclk rise of 0x1F0, then valid word 0x1F8 → outputs reset next edge, no extra sclk edges. After release, the full 0x1F8 is sent and 0x1F0 is not resent.
